// File: rtl/round_ctrl_if.sv
// Match-flow bundle between the round sequencer and the tank/HUD side.
// Latency/backpressure: none here; signals are plain levels and pulses.
interface round_ctrl_if;
    logic       start;
    logic       tank1_dead;
    logic       tank2_dead;
    logic       relife_1;
    logic       relife_2;
    logic [1:0] random_seed_1;
    logic [1:0] random_seed_2;
    logic       freeze;
    logic [2:0] game_state;
    logic [3:0] lives_1;
    logic [3:0] lives_2;
    logic [1:0] winner;
    logic [7:0] timer;

    modport master (
        output start, tank1_dead, tank2_dead,
        input  relife_1, relife_2, random_seed_1, random_seed_2, freeze,
               game_state, lives_1, lives_2, winner, timer
    );

    modport slave (
        input  start, tank1_dead, tank2_dead,
        output relife_1, relife_2, random_seed_1, random_seed_2, freeze,
               game_state, lives_1, lives_2, winner, timer
    );
endinterface

// File: rtl/round_ctrl.sv
// Two-tank match sequencer: countdown, play, respawn pause, game over; lives, seeds, freeze.
// Latency: all outputs registered, one frame after the causing input; no backpressure, dead flags are sticky levels.
module round_ctrl #(
    parameter int LIVES          = 3,
    parameter int START_FRAMES   = 180,
    parameter int RESPAWN_FRAMES = 120,
    parameter int GUARD_FRAMES   = 2
) (
    input  logic         frame_clk,
    input  logic         Reset,
    round_ctrl_if.slave  rc
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t     state;
    logic       freeze;
    logic       relife_1, relife_2;
    logic [1:0] seed_1, seed_2;
    logic [3:0] lives_1, lives_2;
    logic [1:0] winner;
    logic [7:0] timer;
    logic [7:0] guard;
    logic [7:0] lfsr;
    logic [1:0] pend;
    logic       start_q;

    logic       start_edge;
    logic       lfsr_fb;
    logic [3:0] lives_1_nxt, lives_2_nxt;

    always_comb begin
        start_edge  = rc.start & ~start_q;
        lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        lives_1_nxt = lives_1;
        lives_2_nxt = lives_2;
        if (rc.tank1_dead && lives_1 != 4'd0) lives_1_nxt = lives_1 - 4'd1;
        if (rc.tank2_dead && lives_2 != 4'd0) lives_2_nxt = lives_2 - 4'd1;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            freeze   <= 1'b1;
            relife_1 <= 1'b0;
            relife_2 <= 1'b0;
            seed_1   <= 2'd0;
            seed_2   <= 2'd0;
            lives_1  <= 4'(LIVES);
            lives_2  <= 4'(LIVES);
            winner   <= 2'b00;
            timer    <= 8'd0;
            guard    <= 8'd0;
            lfsr     <= 8'hA5;
            pend     <= 2'b00;
            start_q  <= 1'b0;
        end else begin
            start_q  <= rc.start;
            lfsr     <= {lfsr[6:0], lfsr_fb};
            relife_1 <= 1'b0;
            relife_2 <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    freeze <= 1'b1;
                    timer  <= 8'd0;
                    if (start_edge) begin
                        lives_1 <= 4'(LIVES);
                        lives_2 <= 4'(LIVES);
                        winner  <= 2'b00;
                        seed_1  <= lfsr[1:0];
                        seed_2  <= lfsr[3:2];
                        timer   <= 8'(START_FRAMES - 1);
                        state   <= ST_COUNTDOWN;
                    end
                end
                ST_COUNTDOWN: begin
                    freeze <= 1'b1;
                    // Relife follows the seed update by one frame so tanks spawn on settled seeds.
                    if (timer == 8'(START_FRAMES - 1)) begin
                        relife_1 <= 1'b1;
                        relife_2 <= 1'b1;
                    end
                    if (timer == 8'd0) begin
                        state  <= ST_PLAY;
                        freeze <= 1'b0;
                        guard  <= 8'(GUARD_FRAMES);
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_PLAY: begin
                    freeze <= 1'b0;
                    timer  <= 8'd0;
                    if (guard != 8'd0) begin
                        guard <= guard - 8'd1;
                    end else if (rc.tank1_dead || rc.tank2_dead) begin
                        lives_1 <= lives_1_nxt;
                        lives_2 <= lives_2_nxt;
                        freeze  <= 1'b1;
                        if (lives_1_nxt == 4'd0 || lives_2_nxt == 4'd0) begin
                            state  <= ST_GAME_OVER;
                            winner <= {lives_1_nxt == 4'd0, lives_2_nxt == 4'd0};
                        end else begin
                            state <= ST_RESPAWN;
                            timer <= 8'(RESPAWN_FRAMES - 1);
                            pend  <= {rc.tank2_dead, rc.tank1_dead};
                        end
                    end
                end
                ST_RESPAWN: begin
                    freeze <= 1'b1;
                    if (timer == 8'd1) begin
                        if (pend[0]) seed_1 <= lfsr[1:0];
                        if (pend[1]) seed_2 <= lfsr[3:2];
                    end
                    if (timer == 8'd0) begin
                        state    <= ST_PLAY;
                        freeze   <= 1'b0;
                        guard    <= 8'(GUARD_FRAMES);
                        relife_1 <= pend[0];
                        relife_2 <= pend[1];
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    freeze <= 1'b1;
                    timer  <= 8'd0;
                end
            endcase
        end
    end

    assign rc.relife_1      = relife_1;
    assign rc.relife_2      = relife_2;
    assign rc.random_seed_1 = seed_1;
    assign rc.random_seed_2 = seed_2;
    assign rc.freeze        = freeze;
    assign rc.game_state    = state;
    assign rc.lives_1       = lives_1;
    assign rc.lives_2       = lives_2;
    assign rc.winner        = winner;
    assign rc.timer         = timer;
endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: scoreboard of expected state transitions and relife pulses, plus direct checks.
module tb_round_ctrl;
    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    round_ctrl_if bus ();

    round_ctrl #(
        .LIVES(3), .START_FRAMES(4), .RESPAWN_FRAMES(3), .GUARD_FRAMES(2)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .rc(bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] l1;
        logic [3:0] l2;
        logic [1:0] win;
    } rec_t;

    rec_t       exp_q[$];
    logic [1:0] rl_q[$];
    int         total = 0;
    int         bad   = 0;

    logic [7:0] m_lfsr = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic [3:0] el1 = 4'd3, el2 = 4'd3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge frame_clk) begin
        m_prev <= m_lfsr;
        m_lfsr <= Reset ? 8'hA5 : lfsr_step(m_lfsr);
    end

    // Monitor: pops the scoreboard on every state change or relife pulse and checks invariants.
    logic [2:0] prev_st = 3'd0;
    logic [1:0] prev_s1 = 2'd0, prev_s2 = 2'd0;
    rec_t       mon_r;
    logic [1:0] mon_rl;
    always @(posedge frame_clk) begin
        #2;
        if (bus.game_state !== prev_st) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_r = exp_q.pop_front();
                chk("sb_state", bus.game_state, mon_r.st);
                chk("sb_lives1", bus.lives_1, mon_r.l1);
                chk("sb_lives2", bus.lives_2, mon_r.l2);
                chk("sb_winner", bus.winner, mon_r.win);
            end
        end
        if (bus.relife_1 || bus.relife_2) begin
            chk("rl_pending", 32'(rl_q.size() != 0), 1);
            if (rl_q.size() != 0) begin
                mon_rl = rl_q.pop_front();
                chk("rl_pair", {bus.relife_2, bus.relife_1}, mon_rl);
            end
            if (bus.relife_1) chk("seed1_at_relife", bus.random_seed_1, prev_s1);
            if (bus.relife_2) chk("seed2_at_relife", bus.random_seed_2, prev_s2);
        end
        chk("freeze_inv", bus.freeze, bus.game_state != 3'd2);
        if (bus.game_state == 3'd0 || bus.game_state == 3'd2 || bus.game_state == 3'd4)
            chk("timer_zero", bus.timer, 0);
        prev_st = bus.game_state;
        prev_s1 = bus.random_seed_1;
        prev_s2 = bus.random_seed_2;
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Start a match from IDLE/GAME_OVER; returns in the first PLAY cycle. start wiggles during countdown.
    task automatic do_start();
        exp_q.push_back('{st: 3'd1, l1: 4'd3, l2: 4'd3, win: 2'b00});
        exp_q.push_back('{st: 3'd2, l1: 4'd3, l2: 4'd3, win: 2'b00});
        rl_q.push_back(2'b11);
        bus.start = 1'b1;
        tick();
        chk("start_seed1", bus.random_seed_1, m_prev[1:0]);
        chk("start_seed2", bus.random_seed_2, m_prev[3:2]);
        for (int t = 3; t >= 0; t--) begin
            chk("cd_timer", bus.timer, t);
            chk("cd_state", bus.game_state, 1);
            bus.start = t[0];
            tick();
        end
        bus.start = 1'b0;
        chk("play_state", bus.game_state, 2);
        chk("play_freeze", bus.freeze, 0);
        el1 = 4'd3;
        el2 = 4'd3;
    endtask

    // Kill the given tanks; lag = edges until the PLAY logic samples the dead inputs.
    task automatic kill(input bit d1, input bit d2, input int lag);
        logic [3:0] n1, n2;
        logic [1:0] o1, o2;
        bit over;
        n1 = (d1 && el1 != 0) ? el1 - 4'd1 : el1;
        n2 = (d2 && el2 != 0) ? el2 - 4'd1 : el2;
        over = (n1 == 0) || (n2 == 0);
        if (over) begin
            exp_q.push_back('{st: 3'd4, l1: n1, l2: n2, win: {n1 == 0, n2 == 0}});
        end else begin
            exp_q.push_back('{st: 3'd3, l1: n1, l2: n2, win: 2'b00});
            exp_q.push_back('{st: 3'd2, l1: n1, l2: n2, win: 2'b00});
            rl_q.push_back({d2, d1});
        end
        bus.tank1_dead = d1;
        bus.tank2_dead = d2;
        repeat (lag) tick();
        chk("kill_lives1", bus.lives_1, n1);
        chk("kill_lives2", bus.lives_2, n2);
        if (over) begin
            chk("go_state", bus.game_state, 4);
            chk("go_winner", bus.winner, {n1 == 0, n2 == 0});
        end else begin
            chk("rs_state", bus.game_state, 3);
            chk("rs_timer", bus.timer, 2);
            o1 = bus.random_seed_1;
            o2 = bus.random_seed_2;
            tick();
            chk("rs_timer", bus.timer, 1);
            chk("rs_seed1_hold", bus.random_seed_1, o1);
            chk("rs_seed2_hold", bus.random_seed_2, o2);
            tick();
            chk("rs_timer", bus.timer, 0);
            chk("rs_seed1", bus.random_seed_1, d1 ? m_prev[1:0] : o1);
            chk("rs_seed2", bus.random_seed_2, d2 ? m_prev[3:2] : o2);
            tick();
            chk("rs_back_play", bus.game_state, 2);
        end
        bus.tank1_dead = 1'b0;
        bus.tank2_dead = 1'b0;
        el1 = n1;
        el2 = n2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.tank1_dead = 1'b0;
        bus.tank2_dead = 1'b0;
        tick();
        tick();
        chk("rst_state", bus.game_state, 0);
        chk("rst_freeze", bus.freeze, 1);
        chk("rst_lives1", bus.lives_1, 3);
        chk("rst_lives2", bus.lives_2, 3);
        chk("rst_winner", bus.winner, 0);
        chk("rst_timer", bus.timer, 0);
        chk("rst_relife", {bus.relife_2, bus.relife_1}, 0);
        chk("rst_seeds", {bus.random_seed_2, bus.random_seed_1}, 0);
        Reset = 1'b0;
        tick();

        do_start();
        kill(1'b0, 1'b1, 3);

        // Dead during the guard window only, with start wiggling in PLAY.
        bus.tank1_dead = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.tank1_dead = 1'b0;
        bus.start      = 1'b1;
        tick();
        chk("guard_lives1", bus.lives_1, 3);
        chk("guard_state", bus.game_state, 2);
        bus.start = 1'b0;
        tick();
        chk("guard_lives1b", bus.lives_1, 3);

        kill(1'b1, 1'b0, 1);
        kill(1'b1, 1'b1, 3);
        kill(1'b1, 1'b1, 3);

        do_start();
        kill(1'b1, 1'b0, 3);
        kill(1'b1, 1'b0, 3);
        bus.start = 1'b1;
        kill(1'b1, 1'b0, 3);
        repeat (3) tick();
        chk("go_hold_state", bus.game_state, 4);
        chk("go_hold_winner", bus.winner, 2'b10);
        bus.start = 1'b0;
        tick();
        do_start();
        chk("restart_winner", bus.winner, 0);

        // Reset in the middle of a respawn pause.
        exp_q.push_back('{st: 3'd3, l1: 4'd2, l2: 4'd3, win: 2'b00});
        bus.tank1_dead = 1'b1;
        repeat (3) tick();
        chk("mid_timer", bus.timer, 2);
        tick();
        chk("mid_timer", bus.timer, 1);
        Reset = 1'b1;
        exp_q.push_back('{st: 3'd0, l1: 4'd3, l2: 4'd3, win: 2'b00});
        tick();
        chk("mr_state", bus.game_state, 0);
        chk("mr_lives1", bus.lives_1, 3);
        chk("mr_lives2", bus.lives_2, 3);
        chk("mr_freeze", bus.freeze, 1);
        chk("mr_relife", {bus.relife_2, bus.relife_1}, 0);
        chk("mr_seeds", {bus.random_seed_2, bus.random_seed_1}, 0);
        chk("mr_timer", bus.timer, 0);
        Reset          = 1'b0;
        bus.tank1_dead = 1'b0;
        repeat (3) tick();
        chk("mr_idle_hold", bus.game_state, 0);

        chk("sb_drain_state", exp_q.size(), 0);
        chk("sb_drain_relife", rl_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
